// File: rtl/serial_frame_defs_pkg.sv
// -----------------------------------------------------------------------------
// serial_frame_defs
// Shared definitions for the serial frame link (encoder and decoder side).
//   - state_t     : FSM state encodings ST_IDLE / ST_DATA / ST_PAR
//   - START_BIT   : line level that opens a frame
//   - LINE_IDLE   : line level between frames
//   - DEF_DATA_W  : default data bits per frame
//   - DEF_CNT_W   : default bit-index counter width (2**CNT_W >= DATA_W)
//   - frame_len() : total line bits per frame, with or without parity
// -----------------------------------------------------------------------------
package serial_frame_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    localparam logic START_BIT  = 1'b1;
    localparam logic LINE_IDLE  = 1'b0;

    localparam int   DEF_DATA_W = 4;
    localparam int   DEF_CNT_W  = 2;

    // Start bit + data bits (+ parity bit when enabled).
    function automatic int frame_len(input int data_w, input bit par_en);
        return data_w + (par_en ? 2 : 1);
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// -----------------------------------------------------------------------------
// sipo_shift_reg
// Serial-in parallel-out register. Bits enter at the LSB and move toward the
// MSB, so after WIDTH shifts the first bit received sits in the MSB (MSB-first
// framing lands in natural order).
// Ports:
//   clk  in           rising-edge clock
//   clr  in           synchronous clear (priority over en)
//   en   in           shift enable
//   din  in           serial input bit
//   q    out [WIDTH]  parallel register contents
// -----------------------------------------------------------------------------
module sipo_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/serial_frame_decoder.sv
// -----------------------------------------------------------------------------
// serial_frame_decoder
// Receive side of the serial frame link. Waits for a start bit, shifts in
// DATA_W data bits MSB first, undoes the optional line complement (COD latched
// with the start bit) and presents the word on D with a one-cycle Valid pulse.
//
// Build option:
//   DECODER_PARITY_EN  defined   : a trailing even-parity bit follows the data;
//                                  Erro pulses with Valid on a parity mismatch.
//                      undefined : no parity bit, Erro is always 0.
//
// Ports:
//   Clock  in            rising-edge clock
//   Reset  in            synchronous reset, active high, highest priority
//   HAB    in            enable; 0 aborts any frame and holds the block idle
//   COD    in            1 = line carries complemented data (sampled at start)
//   I      in            serial line, idles at 0
//   D      out [DATA_W]  last decoded word (changes only on a completed frame)
//   Valid  out           one-cycle pulse when D is updated
//   Erro   out           parity error flag, pulses with Valid
//   Cout   out [CNT_W]   index of the next data bit expected; 0 outside DATA
// -----------------------------------------------------------------------------
module serial_frame_decoder
    import serial_frame_defs::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              HAB,
    input  logic              COD,
    input  logic              I,
    output logic [DATA_W-1:0] D,
    output logic              Valid,
    output logic              Erro,
    output logic [CNT_W-1:0]  Cout
);

    // Index of the final data bit; the edge where Cout equals this samples it.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    state_t            state;
    logic              cod_q;     // COD captured with the start bit
    logic [DATA_W-1:0] sh_q;      // partial word from the shift register
    logic              sh_clr;
    logic              sh_en;

    // The shift register is cleared whenever no frame is in progress, so a new
    // frame always starts from zero and an aborted frame leaves nothing behind.
    assign sh_clr = Reset | ~HAB | (state == ST_IDLE);
    assign sh_en  = (state == ST_DATA);

    sipo_shift_reg #(
        .WIDTH (DATA_W)
    ) u_sipo (
        .clk (Clock),
        .clr (sh_clr),
        .en  (sh_en),
        .din (I),
        .q   (sh_q)
    );

`ifdef DECODER_PARITY_EN
    // Running XOR of the line data bits; the parity bit is folded in at PAR.
    logic par_acc;
`else
    // Without a parity bit the word completes on the edge that samples the last
    // data bit, so D is built from the shift register's next value.
    logic [DATA_W-1:0] sh_next;
    assign sh_next = {sh_q[DATA_W-2:0], I};
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= ST_IDLE;
            D       <= '0;
            Valid   <= 1'b0;
            Erro    <= 1'b0;
            Cout    <= '0;
            cod_q   <= 1'b0;
`ifdef DECODER_PARITY_EN
            par_acc <= 1'b0;
`endif
        end else begin
            // Pulses: default low, raised only on the completing edge.
            Valid <= 1'b0;
            Erro  <= 1'b0;

            if (!HAB) begin
                // Abort: drop back to idle; D keeps its last good word.
                state <= ST_IDLE;
                Cout  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (I == START_BIT) begin
                            state   <= ST_DATA;
                            Cout    <= '0;
                            cod_q   <= COD;
`ifdef DECODER_PARITY_EN
                            par_acc <= 1'b0;
`endif
                        end
                    end

                    ST_DATA: begin
`ifdef DECODER_PARITY_EN
                        par_acc <= par_acc ^ I;
`endif
                        if (Cout == LAST_IDX) begin
                            Cout  <= '0;
`ifdef DECODER_PARITY_EN
                            state <= ST_PAR;
`else
                            state <= ST_IDLE;
                            D     <= sh_next ^ {DATA_W{cod_q}};
                            Valid <= 1'b1;
`endif
                        end else begin
                            Cout <= Cout + 1'b1;
                        end
                    end

`ifdef DECODER_PARITY_EN
                    ST_PAR: begin
                        // Word is complete in sh_q; this edge samples parity.
                        state <= ST_IDLE;
                        Cout  <= '0;
                        D     <= sh_q ^ {DATA_W{cod_q}};
                        Valid <= 1'b1;
                        Erro  <= par_acc ^ I;
                    end
`endif

                    default: begin
                        state <= ST_IDLE;
                        Cout  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_decoder.sv
module tb_serial_frame_decoder;
    import serial_frame_defs::*;

    localparam int DW = 4;
    localparam int CW = 2;
`ifdef DECODER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FL = PAR_EN ? DW + 2 : DW + 1;

    logic          Clock = 1'b0;
    logic          Reset, HAB, COD, I;
    logic [DW-1:0] D;
    logic          Valid, Erro;
    logic [CW-1:0] Cout;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    serial_frame_decoder #(.DATA_W(DW), .CNT_W(CW)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .HAB   (HAB),
        .COD   (COD),
        .I     (I),
        .D     (D),
        .Valid (Valid),
        .Erro  (Erro),
        .Cout  (Cout)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Start bit, data MSB first, parity bit when built with parity.
    task automatic send_frame(input logic cod, input logic [DW-1:0] data,
                              input logic par, input bit flip_cod);
        COD = cod;
        I   = START_BIT;
        tick();
        if (flip_cod) COD = ~cod;
        for (int k = DW - 1; k >= 0; k--) begin
            I = data[k];
            tick();
        end
        if (PAR_EN) begin
            I = par;
            tick();
        end
        I   = LINE_IDLE;
        COD = cod;
    endtask

    task automatic test_reset();
        logic exp_e;
        Reset = 1'b1; HAB = 1'b0; COD = 1'b0; I = 1'b0;
        tick(); tick();
        n_cmp++; if (D !== 4'b0000) begin n_bad++; $display("FAIL rst_d: got %b want 0000", D); end
        n_cmp++; if (Valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", Valid); end
        n_cmp++; if (Erro !== 1'b0) begin n_bad++; $display("FAIL rst_erro: got %b want 0", Erro); end
        n_cmp++; if (Cout !== 2'd0) begin n_bad++; $display("FAIL rst_cout: got %0d want 0", Cout); end
        // Start a frame, then reset it partway through.
        Reset = 1'b0; HAB = 1'b1;
        I = 1'b1; tick(); I = 1'b1; tick(); I = 1'b0; tick();
        n_cmp++; if (Cout !== 2'd2) begin n_bad++; $display("FAIL pre_rst_cout: got %0d want 2", Cout); end
        Reset = 1'b1; I = 1'b1; tick();
        n_cmp++; if (Cout !== 2'd0) begin n_bad++; $display("FAIL midrst_cout: got %0d want 0", Cout); end
        Reset = 1'b0; I = 1'b0; tick();
        n_cmp++; if (Cout !== 2'd0) begin n_bad++; $display("FAIL postrst_cout: got %0d want 0", Cout); end
        send_frame(1'b0, 4'b1011, 1'b1, 1'b0);
        exp_e = 1'b0;  // 1^0^1^1^1 = 0
        n_cmp++; if (D !== 4'b1011) begin n_bad++; $display("FAIL f1_d: got %b want 1011", D); end
        n_cmp++; if (Valid !== 1'b1) begin n_bad++; $display("FAIL f1_valid: got %b want 1", Valid); end
        n_cmp++; if (Erro !== exp_e) begin n_bad++; $display("FAIL f1_erro: got %b want %b", Erro, exp_e); end
        tick();
        n_cmp++; if (Valid !== 1'b0) begin n_bad++; $display("FAIL f1_valid_drop: got %b want 0", Valid); end
    endtask

    task automatic test_inversion();
        // Line data 0100, parity 1 (even over line bits); COD toggled mid-frame.
        send_frame(1'b1, 4'b0100, 1'b1, 1'b1);
        n_cmp++; if (D !== 4'b1011) begin n_bad++; $display("FAIL inv_d: got %b want 1011", D); end
        n_cmp++; if (Valid !== 1'b1) begin n_bad++; $display("FAIL inv_valid: got %b want 1", Valid); end
        n_cmp++; if (Erro !== 1'b0) begin n_bad++; $display("FAIL inv_erro: got %b want 0", Erro); end
        tick();
        send_frame(1'b1, 4'b1111, 1'b0, 1'b0);
        n_cmp++; if (D !== 4'b0000) begin n_bad++; $display("FAIL inv2_d: got %b want 0000", D); end
        n_cmp++; if (Erro !== 1'b0) begin n_bad++; $display("FAIL inv2_erro: got %b want 0", Erro); end
        tick();
    endtask

    task automatic test_parity_error();
        logic exp_e;
        send_frame(1'b0, 4'b1000, 1'b0, 1'b0);
        exp_e = PAR_EN ? 1'b1 : 1'b0;  // 1^0^0^0^0 = 1 when parity is checked
        n_cmp++; if (D !== 4'b1000) begin n_bad++; $display("FAIL perr_d: got %b want 1000", D); end
        n_cmp++; if (Valid !== 1'b1) begin n_bad++; $display("FAIL perr_valid: got %b want 1", Valid); end
        n_cmp++; if (Erro !== exp_e) begin n_bad++; $display("FAIL perr_erro: got %b want %b", Erro, exp_e); end
        tick();
        n_cmp++; if (Erro !== 1'b0) begin n_bad++; $display("FAIL perr_erro_drop: got %b want 0", Erro); end
        n_cmp++; if (Valid !== 1'b0) begin n_bad++; $display("FAIL perr_valid_drop: got %b want 0", Valid); end
    endtask

    task automatic test_back_to_back();
        int t0;
        send_frame(1'b0, 4'b0011, 1'b0, 1'b0);
        t0 = cyc;
        n_cmp++; if (D !== 4'b0011) begin n_bad++; $display("FAIL b2b_d0: got %b want 0011", D); end
        n_cmp++; if (Valid !== 1'b1) begin n_bad++; $display("FAIL b2b_v0: got %b want 1", Valid); end
        // Next start bit is sampled in the Valid cycle.
        send_frame(1'b0, 4'b1100, 1'b0, 1'b0);
        n_cmp++; if (D !== 4'b1100) begin n_bad++; $display("FAIL b2b_d1: got %b want 1100", D); end
        n_cmp++; if (Valid !== 1'b1) begin n_bad++; $display("FAIL b2b_v1: got %b want 1", Valid); end
        n_cmp++; if (cyc - t0 !== FL) begin n_bad++; $display("FAIL b2b_gap: got %0d want %0d", cyc - t0, FL); end
        n_cmp++; if (Erro !== 1'b0) begin n_bad++; $display("FAIL b2b_erro: got %b want 0", Erro); end
        tick();
    endtask

    task automatic test_abort_recovery();
        logic [DW-1:0] data;
        logic [CW-1:0] exp_c;
        HAB = 1'b1; COD = 1'b0;
        I = 1'b1; tick();
        n_cmp++; if (Cout !== 2'd0) begin n_bad++; $display("FAIL ab_c0: got %0d want 0", Cout); end
        I = 1'b1; tick();
        n_cmp++; if (Cout !== 2'd1) begin n_bad++; $display("FAIL ab_c1: got %0d want 1", Cout); end
        I = 1'b0; tick();
        n_cmp++; if (Cout !== 2'd2) begin n_bad++; $display("FAIL ab_c2: got %0d want 2", Cout); end
        HAB = 1'b0; I = 1'b1; tick();
        n_cmp++; if (Cout !== 2'd0) begin n_bad++; $display("FAIL ab_cout: got %0d want 0", Cout); end
        n_cmp++; if (Valid !== 1'b0) begin n_bad++; $display("FAIL ab_valid: got %b want 0", Valid); end
        n_cmp++; if (D !== 4'b1100) begin n_bad++; $display("FAIL ab_d_hold: got %b want 1100", D); end
        // Line high while disabled must not open a frame.
        tick(); tick();
        HAB = 1'b1; I = 1'b0; tick();
        n_cmp++; if (Cout !== 2'd0) begin n_bad++; $display("FAIL ab_nostart: got %0d want 0", Cout); end
        n_cmp++; if (Valid !== 1'b0) begin n_bad++; $display("FAIL ab_novalid: got %b want 0", Valid); end
        // Full 0110 frame, Cout tracked bit by bit.
        data = 4'b0110;
        I = 1'b1; tick();
        n_cmp++; if (Cout !== 2'd0) begin n_bad++; $display("FAIL rc_c_start: got %0d want 0", Cout); end
        for (int k = 0; k < DW; k++) begin
            I = data[DW-1-k];
            tick();
            exp_c = (k == DW - 1) ? 2'd0 : CW'(k + 1);
            n_cmp++; if (Cout !== exp_c) begin n_bad++; $display("FAIL rc_cout[%0d]: got %0d want %0d", k, Cout, exp_c); end
        end
        n_cmp++; if (Valid !== !PAR_EN) begin n_bad++; $display("FAIL rc_valid_last: got %b want %b", Valid, !PAR_EN); end
        if (PAR_EN) begin
            I = 1'b0; tick();
            n_cmp++; if (Cout !== 2'd0) begin n_bad++; $display("FAIL rc_cout_par: got %0d want 0", Cout); end
        end
        I = 1'b0;
        n_cmp++; if (D !== 4'b0110) begin n_bad++; $display("FAIL rc_d: got %b want 0110", D); end
        n_cmp++; if (Valid !== 1'b1) begin n_bad++; $display("FAIL rc_valid: got %b want 1", Valid); end
        n_cmp++; if (Erro !== 1'b0) begin n_bad++; $display("FAIL rc_erro: got %b want 0", Erro); end
        tick();
        n_cmp++; if (Cout !== 2'd0) begin n_bad++; $display("FAIL rc_cout_idle: got %0d want 0", Cout); end
    endtask

    task automatic test_all_ones();
        HAB = 1'b1; COD = 1'b0;
        I = 1'b1; tick();
        for (int k = 0; k < DW - 1; k++) begin I = 1'b1; tick(); end
        n_cmp++; if (Valid !== 1'b0) begin n_bad++; $display("FAIL ones_early_valid: got %b want 0", Valid); end
        I = 1'b1; tick();
        if (PAR_EN) begin I = 1'b0; tick(); end
        I = 1'b0;
        n_cmp++; if (D !== 4'b1111) begin n_bad++; $display("FAIL ones_d: got %b want 1111", D); end
        n_cmp++; if (Valid !== 1'b1) begin n_bad++; $display("FAIL ones_valid: got %b want 1", Valid); end
        n_cmp++; if (Erro !== 1'b0) begin n_bad++; $display("FAIL ones_erro: got %b want 0", Erro); end
        tick();
        n_cmp++; if (Valid !== 1'b0) begin n_bad++; $display("FAIL ones_valid_drop: got %b want 0", Valid); end
        n_cmp++; if (D !== 4'b1111) begin n_bad++; $display("FAIL ones_d_hold: got %b want 1111", D); end
    endtask

    initial begin
        Reset = 1'b1; HAB = 1'b0; COD = 1'b0; I = 1'b0;
        test_reset();
        test_inversion();
        test_parity_error();
        test_back_to_back();
        test_abort_recovery();
        test_all_ones();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
